// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable bit period, word length and stop bits.
// Optional parity check is built when UART_RX_PARITY_EN is defined.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
      SYNC_STAGES < 2) begin : g_bad_param
    $error("uart_rx_param: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_vld_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   ferr_q;
  logic                   armed_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   data_valid_q;
  logic                   framing_err_q;
  logic                   parity_err_q;
  logic                   overrun_err_q;
  logic                   busy_q;
`ifdef UART_RX_PARITY_EN
  logic                   perr_q;
  logic                   par_exp_d;
`endif

  logic rxs;
  logic rxs_vld;
  logic tick_half_d;
  logic tick_full_d;
  logic ferr_d;
  logic load_d;

  // sync_vld_q marks when rxs carries a real line sample rather than the reset
  // value, so a line held low through reset can never arm the receiver.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '1;
      sync_vld_q <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd};
      sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rxs         = sync_q[SYNC_STAGES-1];
  assign rxs_vld     = sync_vld_q[SYNC_STAGES-1];
  assign tick_half_d = (cnt_q == HALF_M1);
  assign tick_full_d = (cnt_q == FULL_M1);
  assign ferr_d      = ferr_q | ~rxs;
  assign load_d      = ~data_valid_q | data_ready;
`ifdef UART_RX_PARITY_EN
  assign par_exp_d   = (^shift_q) ^ 1'(PARITY_ODD);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      ferr_q        <= 1'b0;
      armed_q       <= 1'b0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q        <= 1'b0;
`endif
    end else begin
      overrun_err_q <= 1'b0;
      if (data_valid_q && data_ready) data_valid_q <= 1'b0;
      if (rxs && rxs_vld) armed_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (armed_q && !rxs) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end

        S_START: begin
          if (tick_half_d) begin
            cnt_q <= '0;
            if (rxs) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          if (tick_full_d) begin
            cnt_q   <= '0;
            shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
            if (idx_q == LAST_DATA) begin
              idx_q   <= '0;
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_full_d) begin
            cnt_q   <= '0;
            perr_q  <= (rxs != par_exp_d);
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (tick_full_d) begin
            cnt_q  <= '0;
            ferr_q <= ferr_d;
            if (idx_q == LAST_STOP) begin
              // Commit at mid stop bit so a back-to-back start bit is still caught.
              idx_q   <= '0;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              if (ferr_d) armed_q <= 1'b0;
              if (load_d) begin
                data_q        <= shift_q;
                framing_err_q <= ferr_d;
`ifdef UART_RX_PARITY_EN
                parity_err_q  <= perr_q;
`else
                parity_err_q  <= 1'b0;
`endif
                data_valid_q  <= 1'b1;
              end else begin
                overrun_err_q <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign framing_err = framing_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = busy_q;

endmodule
